execute_mc: RTL

EXECUTE_MC -- requirements
Module: execute_mc

---
 rtl/execute_mc.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/execute_mc.sv
// ---------------------------------------------------------------------------
// execute_mc
//   Single-issue execute unit. Single-cycle ALU ops (add, sub, logic,
//   bit-reverse, compares, carry-out) and an optional multi-cycle
//   shift-add multiply.
//
// Handshake: an op is taken on a rising clk edge when in_valid && in_ready;
//   a result is handed off on a rising edge when out_valid && out_ready.
//   in_ready is high only in IDLE. out_valid is high only in DONE. While
//   out_valid is high, result/cmp/err stay stable until out_ready is seen.
//
// Ports
//   clk        : clock; all state updates on its rising edge
//   rst        : asynchronous active-low reset
//   in_valid   : upstream op valid
//   in_ready   : block can accept an op (IDLE only)
//   opA, opB   : operands, captured on accept
//   op         : op code (0 ADD .. 10 MUL, 11-15 illegal)
//   out_valid  : result/cmp/err valid (DONE)
//   out_ready  : downstream accepts the result
//   result     : registered result
//   cmp        : registered compare flag (ops 6-9 only)
//   err        : illegal op, disabled MUL, or ADD/SUB signed overflow
//   busy       : high in any state other than IDLE
//   state_dbg  : current FSM state (0 IDLE, 1 MUL, 2 DONE)
// ---------------------------------------------------------------------------
module execute_mc #(
   parameter int WIDTH  = 16,
   parameter int MUL_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cmp,
   output logic             err,
   output logic             busy,
   output logic [1:0]       state_dbg
);

   // Counter must reach WIDTH-1 for the final step without wrapping.
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
   logic [CW-1:0]    cnt_q;

   logic             accept;
   logic             is_mul;
   logic             last_step;
   logic [WIDTH-1:0] step_acc;

   logic [WIDTH:0]   sum_ext;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] rev;
   logic             add_v, sub_v, n_f, z_f;
   logic [WIDTH-1:0] alu_res;
   logic             alu_cmp, alu_err;

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign state_dbg = state_q;

   assign accept = in_valid && in_ready;
   assign is_mul = (op == 4'd10) && (MUL_EN != 0);

   // One shift-add step: multiplicand moves left, multiplier right, LSB first.
   // Bits shifted past WIDTH are dropped, which discards the upper product.
   assign step_acc  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   assign last_step = (cnt_q == CW'(WIDTH - 1));

   // ALU arithmetic shared by ADD/SUB/compares.
   assign sum_ext = {1'b0, opA} + {1'b0, opB};
   assign diff    = opA - opB;
   assign add_v   = (opA[WIDTH-1] == opB[WIDTH-1]) && (sum_ext[WIDTH-1] != opA[WIDTH-1]);
   // V of A-B; N^V gives the true signed less-than even when A-B overflows.
   assign sub_v   = (opA[WIDTH-1] != opB[WIDTH-1]) && (diff[WIDTH-1] != opA[WIDTH-1]);
   assign n_f     = diff[WIDTH-1];
   assign z_f     = (diff == '0);

   always_comb begin
      rev = '0;
      for (int i = 0; i < WIDTH; i++) begin
         rev[i] = opA[WIDTH-1-i];
      end
   end

   always_comb begin
      alu_res = '0;
      alu_cmp = 1'b0;
      alu_err = 1'b0;
      case (op)
         4'd0: begin
            alu_res = sum_ext[WIDTH-1:0];
            alu_err = add_v;
         end
         4'd1: begin
            alu_res = diff;
            alu_err = sub_v;
         end
         4'd2: alu_res = opA & opB;
         4'd3: alu_res = opA | opB;
         4'd4: alu_res = opA ^ opB;
         4'd5: alu_res = rev;
         4'd6: alu_cmp = z_f;
         4'd7: alu_cmp = n_f ^ sub_v;
         4'd8: alu_cmp = (n_f ^ sub_v) | z_f;
         4'd9: alu_cmp = sum_ext[WIDTH];
         // Only reaches the single-cycle path when multiply is disabled.
         4'd10: alu_err = (MUL_EN == 0);
         default: alu_err = 1'b1;
      endcase
      if (op >= 4'd6 && op <= 4'd9) begin
         alu_res = {{(WIDTH-1){1'b0}}, alu_cmp};
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = is_mul ? S_MUL : S_DONE;
            end
         end
         S_MUL: begin
            if (last_step) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: capture on accept, step while multiplying, hold in DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result   <= '0;
         cmp      <= 1'b0;
         err      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  if (is_mul) begin
                     mcand_q  <= opA;
                     mplier_q <= opB;
                     acc_q    <= '0;
                     cnt_q    <= '0;
                  end else begin
                     result <= alu_res;
                     cmp    <= alu_cmp;
                     err    <= alu_err;
                  end
               end
            end
            S_MUL: begin
               acc_q    <= step_acc;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CW'(1);
               if (last_step) begin
                  result <= step_acc;
                  cmp    <= 1'b0;
                  err    <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
